ca_ps_sequencer: RTL and testbench

Start-up/shut-down sequencer for the cathode-anode (CA) power supply protected by the card-1 interlock logic. Drives fan enable and CA_PS_ACT in order, enforces fan-spin, settle and ramp-delay windows, supervises run-time faults, latches trips with a fault code, and locks out after repeated trips. Sits between operator/host commands and the card-1 interlock inputs; all timing counts 64 Hz enable ticks derived from clk.

---
 rtl/ca_ps_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_ca_ps_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ca_ps_sequencer.sv
// Cathode-anode power-supply start-up/shut-down sequencer.
// Orders fan and PS enable, supervises faults, latches trips, locks out.
module ca_ps_sequencer #(
  parameter int FAN_TIMEOUT    = 640,
  parameter int SETTLE_TICKS   = 256,
  parameter int DELAY_TICKS    = 3840,
  parameter int COOLDOWN_TICKS = 1920,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_start_req,
  input  logic       i_stop_req,
  input  logic       i_fault_ack,
  input  logic       i_interlock_ok,
  input  logic       i_fan_ok,
  input  logic       i_g1_ok,
  input  logic       i_i_high,
  input  logic       i_u_low,
  output logic       o_fan_on,
  output logic       o_ps_act,
  output logic       o_ca_delay,
  output logic       o_ca_ok,
  output logic       o_tripped,
  output logic       o_lockout,
  output logic [2:0] o_state,
  output logic [2:0] o_fault_code,
  output logic [2:0] o_retry_cnt
);

  localparam int MAX_AB =
    (FAN_TIMEOUT > SETTLE_TICKS) ? FAN_TIMEOUT : SETTLE_TICKS;
  localparam int MAX_CD =
    (DELAY_TICKS > COOLDOWN_TICKS) ? DELAY_TICKS : COOLDOWN_TICKS;
  localparam int MAX_TICKS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW = $clog2(MAX_TICKS) + 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FAN_START  = 3'd1,
    PS_SETTLE  = 3'd2,
    RAMP_DELAY = 3'd3,
    RUN        = 3'd4,
    SHUTDOWN   = 3'd5,
    TRIP       = 3'd6,
    LOCKOUT    = 3'd7
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [TW-1:0] timer;
  logic [2:0]    flt;
  logic [2:0]    cause;
  logic          fan_exp;
  logic          settle_exp;
  logic          delay_exp;
  logic          cool_exp;
  logic          run_clean;
  logic          trip_entry;
  logic          nxt_fan;
  logic          nxt_ps;
  logic          nxt_dly;
  logic          nxt_ok;
  logic          nxt_trip;
  logic          nxt_lock;

  assign fan_exp    = (timer >= TW'(FAN_TIMEOUT));
  assign settle_exp = (timer >= TW'(SETTLE_TICKS));
  assign delay_exp  = (timer >= TW'(DELAY_TICKS));
  assign cool_exp   = (timer >= TW'(COOLDOWN_TICKS));
  assign trip_entry = (nxt_state == TRIP) && (state != TRIP);
  assign run_clean  = (state == RUN) && delay_exp;

  // Prioritised run-time fault code for the supervised states.
  always_comb begin
    flt = 3'd0;
    if (state inside {FAN_START, PS_SETTLE, RAMP_DELAY, RUN}) begin
      if (!i_interlock_ok)
        flt = 3'd2;
      else if (state != FAN_START && (!i_fan_ok || !i_g1_ok))
        flt = 3'd3;
      else if ((state inside {RAMP_DELAY, RUN}) && i_i_high)
        flt = 3'd4;
      else if (state == RUN && i_u_low)
        flt = 3'd5;
    end
    cause = flt;
    if (flt == 3'd0 && state == FAN_START && fan_exp)
      cause = 3'd1;
  end

  // Next-state selection; faults beat stop and timer expiry.
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:
        if (i_start_req && !i_stop_req && i_interlock_ok)
          nxt_state = FAN_START;
      FAN_START:
        if (cause != 3'd0)
          nxt_state = TRIP;
        else if (i_stop_req)
          nxt_state = SHUTDOWN;
        else if (i_fan_ok && i_g1_ok)
          nxt_state = PS_SETTLE;
      PS_SETTLE:
        if (cause != 3'd0)
          nxt_state = TRIP;
        else if (i_stop_req)
          nxt_state = SHUTDOWN;
        else if (settle_exp)
          nxt_state = RAMP_DELAY;
      RAMP_DELAY:
        if (cause != 3'd0)
          nxt_state = TRIP;
        else if (i_stop_req)
          nxt_state = SHUTDOWN;
        else if (delay_exp)
          nxt_state = RUN;
      RUN:
        if (cause != 3'd0)
          nxt_state = TRIP;
        else if (i_stop_req)
          nxt_state = SHUTDOWN;
      SHUTDOWN:
        if (cool_exp)
          nxt_state = IDLE;
      TRIP:
        if (o_retry_cnt >= 3'(MAX_RETRY))
          nxt_state = LOCKOUT;
        else if (i_fault_ack && i_interlock_ok)
          nxt_state = IDLE;
      LOCKOUT:
        nxt_state = LOCKOUT;
      default:
        nxt_state = IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below.
  always_comb begin
    nxt_fan  = 1'b0;
    nxt_ps   = 1'b0;
    nxt_dly  = 1'b0;
    nxt_ok   = 1'b0;
    nxt_trip = 1'b0;
    nxt_lock = 1'b0;
    unique case (1'b1)
      (nxt_state == FAN_START): nxt_fan = 1'b1;
      (nxt_state == PS_SETTLE): begin
        nxt_fan = 1'b1;
        nxt_ps  = 1'b1;
      end
      (nxt_state == RAMP_DELAY): begin
        nxt_fan = 1'b1;
        nxt_ps  = 1'b1;
        nxt_dly = 1'b1;
      end
      (nxt_state == RUN): begin
        nxt_fan = 1'b1;
        nxt_ps  = 1'b1;
        nxt_ok  = 1'b1;
      end
      (nxt_state == SHUTDOWN): nxt_fan  = 1'b1;
      (nxt_state == TRIP):     nxt_trip = 1'b1;
      (nxt_state == LOCKOUT):  nxt_lock = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nxt_state;
  end

  // Tick timer, cleared on every state change, saturating.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (nxt_state != state)
      timer <= '0;
    else if (i_tick && timer != '1)
      timer <= timer + 1'b1;
  end

  // Registered drive and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_fan_on   <= 1'b0;
      o_ps_act   <= 1'b0;
      o_ca_delay <= 1'b0;
      o_ca_ok    <= 1'b0;
      o_tripped  <= 1'b0;
      o_lockout  <= 1'b0;
    end else begin
      o_fan_on   <= nxt_fan;
      o_ps_act   <= nxt_ps;
      o_ca_delay <= nxt_dly;
      o_ca_ok    <= nxt_ok;
      o_tripped  <= nxt_trip;
      o_lockout  <= nxt_lock;
    end
  end

  // Trip bookkeeping: latch cause, count trips, forgive after clean run.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_fault_code <= 3'd0;
      o_retry_cnt  <= 3'd0;
    end else if (trip_entry) begin
      o_fault_code <= cause;
      if (o_retry_cnt != 3'd7)
        o_retry_cnt <= o_retry_cnt + 3'd1;
    end else if (run_clean) begin
      o_retry_cnt <= 3'd0;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_ca_ps_sequencer.sv
// Vector-table bench for the CA power-supply sequencer.
// Expected outputs queued at drive time, popped after each edge.
module tb_ca_ps_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tick;
  logic       start_req;
  logic       stop_req;
  logic       fault_ack;
  logic       ilk_ok;
  logic       fan_ok;
  logic       g1_ok;
  logic       i_high;
  logic       u_low;
  logic       fan_on;
  logic       ps_act;
  logic       ca_delay;
  logic       ca_ok;
  logic       tripped;
  logic       lockout;
  logic [2:0] state;
  logic [2:0] fault_code;
  logic [2:0] retry_cnt;

  ca_ps_sequencer #(
    .FAN_TIMEOUT   (8),
    .SETTLE_TICKS  (4),
    .DELAY_TICKS   (16),
    .COOLDOWN_TICKS(8),
    .MAX_RETRY     (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_tick        (tick),
    .i_start_req   (start_req),
    .i_stop_req    (stop_req),
    .i_fault_ack   (fault_ack),
    .i_interlock_ok(ilk_ok),
    .i_fan_ok      (fan_ok),
    .i_g1_ok       (g1_ok),
    .i_i_high      (i_high),
    .i_u_low       (u_low),
    .o_fan_on      (fan_on),
    .o_ps_act      (ps_act),
    .o_ca_delay    (ca_delay),
    .o_ca_ok       (ca_ok),
    .o_tripped     (tripped),
    .o_lockout     (lockout),
    .o_state       (state),
    .o_fault_code  (fault_code),
    .o_retry_cnt   (retry_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic       sta;
    logic       stp;
    logic       ack;
    logic       ilk;
    logic       fan;
    logic       g1;
    logic       ih;
    logic       ul;
    logic [7:0] n;
    logic [2:0] es;
    logic [2:0] ec;
    logic [2:0] er;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [14:0] exp_out(
    input logic [2:0] s, input logic [2:0] c, input logic [2:0] r);
    logic f, p, d, k, t, l;
    f = (s >= 3'd1) && (s <= 3'd5);
    p = (s >= 3'd2) && (s <= 3'd4);
    d = (s == 3'd3);
    k = (s == 3'd4);
    t = (s == 3'd6);
    l = (s == 3'd7);
    return {s, f, p, d, k, t, l, c, r};
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic sta, input logic stp,
    input logic ack, input logic ilk, input logic fan,
    input logic g1, input logic ih, input logic ul,
    input int n, input int es, input int ec, input int er);
    vec_t t;
    t.rst = rst; t.sta = sta; t.stp = stp; t.ack = ack;
    t.ilk = ilk; t.fan = fan; t.g1 = g1; t.ih = ih; t.ul = ul;
    t.n  = 8'(n);
    t.es = 3'(es);
    t.ec = 3'(ec);
    t.er = 3'(er);
    return t;
  endfunction

  task automatic apply(input vec_t t, input string name);
    logic [14:0] got;
    logic [14:0] want;
    for (int i = 0; i < int'(t.n); i++) begin
      reset     = t.rst;
      start_req = t.sta;
      stop_req  = t.stp;
      fault_ack = t.ack;
      ilk_ok    = t.ilk;
      fan_ok    = t.fan;
      g1_ok     = t.g1;
      i_high    = t.ih;
      u_low     = t.ul;
      if (i == int'(t.n) - 1)
        sb.push_back(exp_out(t.es, t.ec, t.er));
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        want = sb.pop_front();
        got  = {state, fan_on, ps_act, ca_delay, ca_ok,
                tripped, lockout, fault_code, retry_cnt};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s: got st=%0d outs=%b code=%0d retry=%0d, want st=%0d outs=%b code=%0d retry=%0d",
                   name, got[14:12], got[11:6], got[5:3], got[2:0],
                   want[14:12], want[11:6], want[5:3], want[2:0]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1;
    start_req = 1'b0; stop_req = 1'b0; fault_ack = 1'b0;
    ilk_ok = 1'b1; fan_ok = 1'b0; g1_ok = 1'b0;
    i_high = 1'b0; u_low = 1'b0;

    // rst sta stp ack ilk fan g1 ih ul | n | state code retry
    vecs.push_back(mk(1,0,0,0,1,0,0,0,0,  2, 0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0,  1, 0,0,0));
    // happy path with masked monitors, then stop and cooldown
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,  2, 1,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 2,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,1,  2, 2,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  2, 2,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 3,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,1,  3, 3,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0, 13, 3,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 4,0,0));
    vecs.push_back(mk(0,0,1,0,1,1,1,0,0,  1, 5,0,0));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  8, 5,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,  1, 0,0,0));
    // fan never spins up
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,  8, 1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,  1, 6,1,1));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,  2, 6,1,1));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,0,  1, 0,1,1));
    // I_high + U_low + stop together in RUN
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,1,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 2,1,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  5, 3,1,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0, 17, 4,1,1));
    vecs.push_back(mk(0,0,1,0,1,1,1,1,1,  1, 6,4,2));
    vecs.push_back(mk(0,0,0,1,1,1,1,0,0,  1, 0,4,2));
    // I_high in RAMP_DELAY: third trip, then lockout
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,4,2));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 2,4,2));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  5, 3,4,2));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,0,  1, 6,4,3));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 7,4,3));
    vecs.push_back(mk(0,1,0,1,1,1,1,0,0,  3, 7,4,3));
    vecs.push_back(mk(1,0,0,0,1,0,0,0,0,  1, 0,0,0));
    // interlock loss in FAN_START; ack needs interlock good
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,  1, 6,2,1));
    vecs.push_back(mk(0,0,0,1,0,0,0,0,0,  1, 6,2,1));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,0,  1, 0,2,1));
    // clean RUN clears retry count, then U_low trips
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,2,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 2,2,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  5, 3,2,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0, 17, 4,2,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0, 16, 4,2,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 4,2,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,1,  1, 6,5,1));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,0,  1, 0,5,1));
    // G1 loss in PS_SETTLE, then reset mid-sequence
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,5,1));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,0,  1, 2,5,1));
    vecs.push_back(mk(0,0,0,0,1,1,0,0,0,  1, 6,3,2));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,0,  1, 0,3,2));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0,  1, 1,3,2));
    vecs.push_back(mk(1,0,0,0,1,0,0,0,0,  1, 0,0,0));

    foreach (vecs[k])
      apply(vecs[k], $sformatf("vec%0d", k));

    // no ticks: FAN_START must not time out
    apply(mk(0,1,0,0,1,0,0,0,0,  1, 1,0,0), "notick_enter");
    tick = 1'b0;
    apply(mk(0,0,0,0,1,0,0,0,0, 20, 1,0,0), "notick_hold");
    tick = 1'b1;
    apply(mk(0,0,0,0,1,0,0,0,0,  8, 1,0,0), "tick_resume");
    apply(mk(0,0,0,0,1,0,0,0,0,  1, 6,1,1), "tick_timeout");
    apply(mk(0,0,0,1,1,0,0,0,0,  1, 0,1,1), "tick_ack");

    // stop during PS_SETTLE drops ps_act at once
    apply(mk(0,1,0,0,1,0,0,0,0,  1, 1,1,1), "settle_stop_a");
    apply(mk(0,0,0,0,1,1,1,0,0,  2, 2,1,1), "settle_stop_b");
    apply(mk(0,0,1,0,1,1,1,0,0,  1, 5,1,1), "settle_stop_c");
    apply(mk(0,0,0,0,1,0,0,0,0,  8, 5,1,1), "settle_stop_d");
    apply(mk(0,0,0,0,1,0,0,0,0,  1, 0,1,1), "settle_stop_e");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
